dlart_multi: RTL and testbench
==============================

Name: dlart_multi

Overview:
- Parametrised successor to the single hard-wired console DLART: NCH DL11-compatible serial channels, each with RX and TX FIFOs of depth DEPTH.
- Sits between the DCJ11 bus-cycle decoder and the console/host byte ports.
- Channel 0 decodes at the console addresses. Channels 1..NCH-1 decode at the DL11 auxiliary block.
- Adds DL11 interrupt-enable bits, per-channel interrupt requests, overrun reporting and bus INIT clearing.

Parameters:
- NCH, 4, number of channels, 1..16.
- DEPTH, 8, FIFO entries per direction, power of two, 2..64.
- CH0_BASE, 22'o17777560, RCSR address of channel 0.
- CHN_BASE, 22'o17776500, RCSR address of channel 1. Channel k≥1 sits at CHN_BASE+8*(k-1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- bus_addr  in  22  latched physical address.
- bus_bs  in  2  bank select. Decode only when 2'b10 (external I/O).
- bus_rd  in  1  one-cycle read strobe.
- bus_wr  in  1  one-cycle write strobe.
- bus_byte  in  1  byte write.
- bus_wdata  in  16  write data.
- bus_rdata  out  16  read data, combinational from decode.
- bus_hit  out  1  address decodes to a register. Used by NXM logic.
- bus_init  in  1  one-cycle bus INIT (GP code 014).
- rx_wr  in  NCH  host push strobe per channel.
- rx_wdata  in  8*NCH  host push bytes, channel k at [8k+7:8k].
- rx_full  out  NCH  RX FIFO full.
- tx_rd  in  NCH  host pop strobe.
- tx_rdata  out  8*NCH  TX FIFO head, first-word-fall-through.
- tx_empty  out  NCH  TX FIFO empty.
- rx_irq  out  NCH  receiver interrupt request.
- tx_irq  out  NCH  transmitter interrupt request.

Interface decision: one clock; reset is asynchronous and active-low — clock port clk, reset port rst_n.

Behaviour:
- Reset (rst_n low, asynchronous) state:
  - All FIFOs empty.
  - RIE, TIE, MAINT = 0; overrun flags = 0.
  - rx_full = 0, tx_empty = all ones, tx_rdata = 0, irqs = 0.
- bus_init state, synchronous, one cycle: same as reset.
- Registers per channel, offsets from the channel base:
  - +0 RCSR: bit7 DONE (RX not empty, RO), bit6 RIE (RW), other bits read 0.
  - +2 RBUF: bit15 ERR, bit14 OR, bits7:0 head byte. Read-only; writes are ignored.
  - +4 XCSR: bit7 RDY (TX not full, RO), bit6 TIE (RW), bit2 MAINT (RW, optional feature only), other bits 0.
  - +6 XBUF: write pushes wdata[7:0]; reads return 0.
- Address and decode:
  - bus_addr[0] is ignored for the register select.
  - A byte write with bus_addr[0]=1 (high byte) changes nothing.
  - bus_hit = bs==10 and the address lies in any channel window. It is combinational.
  - bus_rdata = 0 when bus_hit=0.
- RBUF read side effects:
  - The head is returned combinationally.
  - At the clk edge with bus_rd=1, the FIFO is popped if not empty and the OR flag is cleared.
  - Read while empty: returns {OR,OR,14'b0}, clears OR, no pop.
- RX push:
  - rx_wr while not full: enqueue.
  - rx_wr while full, with no same-cycle pop: byte dropped, OR set (sticky).
  - rx_wr while full with a same-cycle RBUF pop: accepted, count unchanged.
- XBUF write:
  - Not full: enqueue.
  - Full: byte dropped silently. Software must poll RDY.
  - Simultaneous tx_rd on a full FIFO: accepted.
- tx_rd while empty: ignored.
- FIFO count range is 0..DEPTH with DEPTH+1 states. Pointers wrap modulo DEPTH.
- Interrupt outputs are level-sensitive, registered, and updated the cycle after any state change:
  - rx_irq[k] = RIE & DONE.
  - tx_irq[k] = TIE & RDY.
- Latency:
  - A host push is visible in DONE on the next cycle.
  - A bus write is visible on tx_rdata/tx_empty on the next cycle.
- bus_rd and bus_wr together in the same cycle: bus_wr takes priority and the read side effect is suppressed.

Optional Feature:
- Macro: DLART_LOOPBACK_EN.
- When defined:
  - XCSR bit2 MAINT is RW.
  - While MAINT=1, an XBUF write is routed into that channel's RX FIFO using the same overrun rules.
  - The TX FIFO is not written, rx_wr for that channel is ignored, and tx_empty is forced to 1.
- When undefined:
  - MAINT reads 0 and writes are ignored.
  - No loopback logic is generated.

Test Plan:
- Reset then read ch0 XCSR@17777564 -> 16'o000200. Read RCSR@17777560 -> 0. tx_empty=all ones.
- rx_wr[0] with 8'h41; read RCSR -> 16'o200; read RBUF@17777562 -> 16'h0041, then RCSR -> 0.
- Fill ch1 RX with DEPTH pushes plus one extra 8'h5A:
  - rx_full[1]=1.
  - First RBUF read @17776502 -> bit15 and bit14 set with the first byte; the second read has the flags clear.
  - Drained count = DEPTH.
- Write TIE (16'o100) to ch2 XCSR @17776514 -> tx_irq[2]=1 next cycle.
  - Fill TX with DEPTH writes -> tx_irq[2]=0, RDY=0.
  - One tx_rd -> tx_irq[2]=1.
- Read @17776540 (beyond NCH=4) -> bus_hit=0. Byte write of 8'h55 to 17777567 -> tx_empty[0] stays 1.
- bus_init with all FIFOs partly full and RIE set -> all FIFOs empty, irqs 0, RCSR reads 0. With DLART_LOOPBACK_EN: MAINT set, XBUF write 8'h33 -> RBUF reads 16'h0033.

Source files
------------

// File: rtl/dlart_multi.sv
// dlart_multi: NCH DL11-compatible serial channels behind the DCJ11 bus decoder.
// Each channel has RCSR/RBUF/XCSR/XBUF at base+0/2/4/6, an RX FIFO filled by
// the host and drained by RBUF reads, and a TX FIFO filled by XBUF writes and
// drained by the host. Channel 0 sits at CH0_BASE, channel k>=1 at
// CHN_BASE+8*(k-1).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   bus_addr/bus_bs       physical address and bank select (2'b10 = I/O page)
//   bus_rd/bus_wr         one-cycle read/write strobes, bus_byte = byte write
//   bus_wdata/bus_rdata   write data / combinational read data
//   bus_hit               address decodes to one of the channel registers
//   bus_init              one-cycle bus INIT, same effect as reset
//   rx_wr/rx_wdata/rx_full   host-side RX push per channel
//   tx_rd/tx_rdata/tx_empty  host-side TX pop per channel (first-word-fall-through)
//   rx_irq/tx_irq         registered level interrupt requests
//
// Optional feature: define DLART_LOOPBACK_EN to enable XCSR MAINT loopback
// (XBUF writes are routed into the same channel's RX FIFO while MAINT=1).
module dlart_multi #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned DEPTH    = 8,
  parameter logic [21:0] CH0_BASE = 22'o17777560,
  parameter logic [21:0] CHN_BASE = 22'o17776500
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [21:0]          bus_addr,
  input  logic [1:0]           bus_bs,
  input  logic                 bus_rd,
  input  logic                 bus_wr,
  input  logic                 bus_byte,
  input  logic [15:0]          bus_wdata,
  output logic [15:0]          bus_rdata,
  output logic                 bus_hit,
  input  logic                 bus_init,
  input  logic [NCH-1:0]       rx_wr,
  input  logic [8*NCH-1:0]     rx_wdata,
  output logic [NCH-1:0]       rx_full,
  input  logic [NCH-1:0]       tx_rd,
  output logic [8*NCH-1:0]     tx_rdata,
  output logic [NCH-1:0]       tx_empty,
  output logic [NCH-1:0]       rx_irq,
  output logic [NCH-1:0]       tx_irq
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    REG_RCSR = 2'd0,
    REG_RBUF = 2'd1,
    REG_XCSR = 2'd2,
    REG_XBUF = 2'd3
  } reg_e;

  reg_e           rsel;
  logic           io_page;
  logic           wr_en;
  logic           rd_en;
  logic [NCH-1:0] sel;
  logic [15:0]    ch_rdata [NCH];
  logic           unused_wdata;

  assign rsel    = reg_e'(bus_addr[2:1]);
  assign io_page = (bus_bs == 2'b10);
  // High-byte writes touch no implemented bit, so they are dropped entirely.
  assign wr_en   = bus_wr && !(bus_byte && bus_addr[0]);
  // A write in the same cycle wins: the RBUF pop side effect is suppressed.
  assign rd_en   = bus_rd && !bus_wr;
  assign bus_hit = |sel;
  assign unused_wdata = ^{bus_wdata[15:8], bus_wdata[5:0]};

  // At most one channel is selected, and unselected channels drive zero.
  always_comb begin
    bus_rdata = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      bus_rdata = bus_rdata | ch_rdata[k];
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    localparam logic [21:0] BASE = (k == 0) ? CH0_BASE : CHN_BASE + 22'(8 * (k - 1));

    logic          hit_ch, wr_ch, rd_rbuf, xbuf_wr, lb;
    logic          rie, tie, ovr, rx_irq_q, tx_irq_q;
    logic [15:0]   rdata_ch;

    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] rx_wp, rx_rp;
    logic [AW:0]   rx_cnt;
    logic          rx_empty, rx_full_i, rx_src_wr, rx_push, rx_pop, rx_ovr;
    logic [7:0]    rx_src_data, rx_head;

    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] tx_wp, tx_rp;
    logic [AW:0]   tx_cnt;
    logic          tx_empty_i, tx_full_i, tx_push_req, tx_push, tx_pop;

    assign hit_ch  = io_page && (bus_addr[21:3] == BASE[21:3]);
    assign sel[k]  = hit_ch;
    assign wr_ch   = wr_en && hit_ch;
    assign xbuf_wr = wr_ch && (rsel == REG_XBUF);
    assign rd_rbuf = rd_en && hit_ch && (rsel == REG_RBUF);

`ifdef DLART_LOOPBACK_EN
    logic maint;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        maint <= 1'b0;
      end else if (bus_init) begin
        maint <= 1'b0;
      end else if (wr_ch && (rsel == REG_XCSR)) begin
        maint <= bus_wdata[2];
      end
    end

    assign lb          = maint;
    assign rx_src_wr   = maint ? xbuf_wr : rx_wr[k];
    assign rx_src_data = maint ? bus_wdata[7:0] : rx_wdata[8*k +: 8];
    assign tx_push_req = xbuf_wr && !maint;
`else
    assign lb          = 1'b0;
    assign rx_src_wr   = rx_wr[k];
    assign rx_src_data = rx_wdata[8*k +: 8];
    assign tx_push_req = xbuf_wr;
`endif

    // RX FIFO: a push into a full FIFO is still accepted when an RBUF pop
    // frees the slot in the same cycle; otherwise it is an overrun.
    assign rx_empty  = (rx_cnt == '0);
    assign rx_full_i = (rx_cnt == FULL_CNT);
    assign rx_pop    = rd_rbuf && !rx_empty;
    assign rx_push   = rx_src_wr && (!rx_full_i || rx_pop);
    assign rx_ovr    = rx_src_wr && rx_full_i && !rx_pop;
    assign rx_head   = rx_empty ? 8'h00 : rx_mem[rx_rp];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rx_wp  <= '0;
        rx_rp  <= '0;
        rx_cnt <= '0;
      end else if (bus_init) begin
        rx_wp  <= '0;
        rx_rp  <= '0;
        rx_cnt <= '0;
      end else begin
        if (rx_push) rx_wp <= rx_wp + 1'b1;
        if (rx_pop)  rx_rp <= rx_rp + 1'b1;
        if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + 1'b1;
        else if (rx_pop && !rx_push) rx_cnt <= rx_cnt - 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wp] <= rx_src_data;
    end

    // TX FIFO: full writes are dropped unless the host pops in the same cycle.
    assign tx_empty_i = (tx_cnt == '0);
    assign tx_full_i  = (tx_cnt == FULL_CNT);
    assign tx_pop     = tx_rd[k] && !tx_empty_i && !lb;
    assign tx_push    = tx_push_req && (!tx_full_i || tx_pop);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tx_wp  <= '0;
        tx_rp  <= '0;
        tx_cnt <= '0;
      end else if (bus_init) begin
        tx_wp  <= '0;
        tx_rp  <= '0;
        tx_cnt <= '0;
      end else begin
        if (tx_push) tx_wp <= tx_wp + 1'b1;
        if (tx_pop)  tx_rp <= tx_rp + 1'b1;
        if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + 1'b1;
        else if (tx_pop && !tx_push) tx_cnt <= tx_cnt - 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp] <= bus_wdata[7:0];
    end

    // Control bits, sticky overrun and registered interrupt levels.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rie      <= 1'b0;
        tie      <= 1'b0;
        ovr      <= 1'b0;
        rx_irq_q <= 1'b0;
        tx_irq_q <= 1'b0;
      end else if (bus_init) begin
        rie      <= 1'b0;
        tie      <= 1'b0;
        ovr      <= 1'b0;
        rx_irq_q <= 1'b0;
        tx_irq_q <= 1'b0;
      end else begin
        if (wr_ch && (rsel == REG_RCSR)) rie <= bus_wdata[6];
        if (wr_ch && (rsel == REG_XCSR)) tie <= bus_wdata[6];
        if (rx_ovr)       ovr <= 1'b1;
        else if (rd_rbuf) ovr <= 1'b0;
        rx_irq_q <= rie && !rx_empty;
        tx_irq_q <= tie && !tx_full_i;
      end
    end

    always_comb begin
      rdata_ch = '0;
      if (hit_ch) begin
        case (rsel)
          REG_RCSR: begin
            rdata_ch[7] = !rx_empty;
            rdata_ch[6] = rie;
          end
          REG_RBUF: rdata_ch = {ovr, ovr, 6'b0, rx_head};
          REG_XCSR: begin
            rdata_ch[7] = !tx_full_i;
            rdata_ch[6] = tie;
            rdata_ch[2] = lb;
          end
          default: rdata_ch = '0;
        endcase
      end
    end

    assign ch_rdata[k]         = rdata_ch;
    assign rx_full[k]          = rx_full_i;
    assign tx_empty[k]         = tx_empty_i || lb;
    assign tx_rdata[8*k +: 8]  = tx_empty_i ? 8'h00 : tx_mem[tx_rp];
    assign rx_irq[k]           = rx_irq_q;
    assign tx_irq[k]           = tx_irq_q;
  end

endmodule

// File: tb/tb_dlart_multi.sv
// Scoreboard bench for dlart_multi (NCH=4, DEPTH=8). Stimulus tasks push the
// expected response into a queue; the monitor pops and compares on each bus
// read strobe (read data + hit) or status probe strobe (host-side outputs).
module tb_dlart_multi;

  localparam int unsigned NCH   = 4;
  localparam int unsigned DEPTH = 8;

  localparam logic [21:0] RCSR0 = 22'o17777560;
  localparam logic [21:0] RBUF0 = 22'o17777562;
  localparam logic [21:0] XCSR0 = 22'o17777564;
  localparam logic [21:0] XBUF0 = 22'o17777566;
  localparam logic [21:0] RCSR1 = 22'o17776500;
  localparam logic [21:0] RBUF1 = 22'o17776502;
  localparam logic [21:0] XCSR2 = 22'o17776514;
  localparam logic [21:0] XBUF2 = 22'o17776516;
  localparam logic [21:0] RCSR3 = 22'o17776520;
  localparam logic [21:0] RBUF3 = 22'o17776522;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [21:0]        bus_addr = '0;
  logic [1:0]         bus_bs = 2'b10;
  logic               bus_rd = 1'b0;
  logic               bus_wr = 1'b0;
  logic               bus_byte = 1'b0;
  logic [15:0]        bus_wdata = '0;
  logic [15:0]        bus_rdata;
  logic               bus_hit;
  logic               bus_init = 1'b0;
  logic [NCH-1:0]     rx_wr = '0;
  logic [8*NCH-1:0]   rx_wdata = '0;
  logic [NCH-1:0]     rx_full;
  logic [NCH-1:0]     tx_rd = '0;
  logic [8*NCH-1:0]   tx_rdata;
  logic [NCH-1:0]     tx_empty;
  logic [NCH-1:0]     rx_irq;
  logic [NCH-1:0]     tx_irq;

  dlart_multi #(.NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .bus_addr(bus_addr), .bus_bs(bus_bs), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .bus_byte(bus_byte), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_hit(bus_hit), .bus_init(bus_init),
    .rx_wr(rx_wr), .rx_wdata(rx_wdata), .rx_full(rx_full),
    .tx_rd(tx_rd), .tx_rdata(tx_rdata), .tx_empty(tx_empty),
    .rx_irq(rx_irq), .tx_irq(tx_irq)
  );

  always #5 clk = ~clk;

  // Status word: {tx_rdata[31:0], rx_full[3:0], tx_empty[3:0], rx_irq[3:0], tx_irq[3:0]}
  logic [47:0] st;
  assign st = {tx_rdata, rx_full, tx_empty, rx_irq, tx_irq};

  typedef struct {
    string       nm;
    logic [15:0] exp;
    logic        hit;
  } rd_t;

  typedef struct {
    string       nm;
    logic [47:0] mask;
    logic [47:0] exp;
  } st_t;

  rd_t  rd_q[$];
  st_t  st_q[$];
  logic probe_r = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Monitor: compares away from the active edge.
  always @(negedge clk) begin
    rd_t re;
    st_t se;
    if (bus_rd) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_underflow: read strobe with no expected entry, rdata=%h", bus_rdata);
      end else begin
        re = rd_q.pop_front();
        if (bus_rdata !== re.exp || bus_hit !== re.hit) begin
          errors++;
          $display("FAIL %s: got rdata=%h hit=%b, expected rdata=%h hit=%b",
                   re.nm, bus_rdata, bus_hit, re.exp, re.hit);
        end
      end
    end
    if (probe_r) begin
      checks++;
      if (st_q.size() == 0) begin
        errors++;
        $display("FAIL st_underflow: probe with no expected entry, st=%h", st);
      end else begin
        se = st_q.pop_front();
        if ((st & se.mask) !== se.exp) begin
          errors++;
          $display("FAIL %s: got status=%h, expected %h (mask %h)",
                   se.nm, st & se.mask, se.exp, se.mask);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [21:0] a, input logic [15:0] exp,
                          input logic hit, input string nm);
    rd_q.push_back('{nm, exp, hit});
    bus_addr = a;
    bus_rd   = 1'b1;
    tick();
    bus_rd   = 1'b0;
  endtask

  task automatic bus_write(input logic [21:0] a, input logic [15:0] d, input logic bt);
    bus_addr  = a;
    bus_wdata = d;
    bus_byte  = bt;
    bus_wr    = 1'b1;
    tick();
    bus_wr    = 1'b0;
    bus_byte  = 1'b0;
  endtask

  task automatic rx_push(input int ch, input logic [7:0] b);
    rx_wr              = '0;
    rx_wr[ch]          = 1'b1;
    rx_wdata[8*ch +: 8] = b;
    tick();
    rx_wr = '0;
  endtask

  task automatic tx_pop(input int ch);
    tx_rd     = '0;
    tx_rd[ch] = 1'b1;
    tick();
    tx_rd = '0;
  endtask

  task automatic probe(input logic [47:0] mask, input logic [47:0] exp, input string nm);
    st_q.push_back('{nm, mask, exp});
    probe_r = 1'b1;
    tick();
    probe_r = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Reset state
    probe(48'hFFFF_FFFF_FFFF, 48'h0000_0000_0F00, "reset_status");
    bus_read(XCSR0, 16'o000200, 1'b1, "reset_xcsr0");
    bus_read(RCSR0, 16'o000000, 1'b1, "reset_rcsr0");

    // Single byte through channel 0 RX
    rx_push(0, 8'h41);
    bus_read(RCSR0, 16'o000200, 1'b1, "rcsr0_done");
    bus_read(RBUF0, 16'h0041, 1'b1, "rbuf0_byte");
    bus_read(RCSR0, 16'o000000, 1'b1, "rcsr0_drained");

    // Channel 1 overrun: DEPTH pushes plus one dropped byte
    for (int i = 0; i < DEPTH; i++) rx_push(1, 8'h10 + 8'(i));
    rx_push(1, 8'h5A);
    probe(48'h0000_0000_2000, 48'h0000_0000_2000, "rx_full1");
    bus_read(RBUF1, 16'hC010, 1'b1, "rbuf1_overrun");
    for (int i = 1; i < DEPTH; i++) bus_read(RBUF1, 16'h0010 + 16'(i), 1'b1, "rbuf1_drain");
    bus_read(RCSR1, 16'o000000, 1'b1, "rcsr1_drained");
    bus_read(RBUF1, 16'h0000, 1'b1, "rbuf1_empty");

    // Channel 3: push into full FIFO with same-cycle RBUF pop is accepted
    for (int i = 0; i < DEPTH; i++) rx_push(3, 8'h30 + 8'(i));
    rd_q.push_back('{"rbuf3_pop_push", 16'h0030, 1'b1});
    bus_addr = RBUF3;
    bus_rd = 1'b1;
    rx_wr[3] = 1'b1;
    rx_wdata[31:24] = 8'h38;
    tick();
    bus_rd = 1'b0;
    rx_wr = '0;
    probe(48'h0000_0000_8000, 48'h0000_0000_8000, "rx_full3_kept");
    for (int i = 1; i <= DEPTH; i++) bus_read(RBUF3, 16'h0030 + 16'(i), 1'b1, "rbuf3_drain");
    bus_read(RCSR3, 16'o000000, 1'b1, "rcsr3_drained");

    // Channel 2 TX interrupt and full behaviour
    bus_write(XCSR2, 16'o000100, 1'b0);
    tick();
    probe(48'h0000_0000_0404, 48'h0000_0000_0404, "tie2_irq");
    for (int i = 0; i < DEPTH; i++) bus_write(XBUF2, 16'h00A0 + 16'(i), 1'b0);
    bus_write(XBUF2, 16'h00EE, 1'b0);
    tick();
    probe(48'h00FF_0000_0404, 48'h00A0_0000_0000, "tx2_full");
    bus_read(XCSR2, 16'o000100, 1'b1, "xcsr2_full");
    tx_pop(2);
    tick();
    probe(48'h00FF_0000_0004, 48'h00A1_0000_0004, "tx2_one_pop");
    for (int i = 1; i < DEPTH; i++) tx_pop(2);
    probe(48'h00FF_0000_0400, 48'h0000_0000_0400, "tx2_drained");

    // Decode boundaries
    bus_read(22'o17776540, 16'h0000, 1'b0, "miss_ch5");
    bus_read(22'o17776530, 16'h0000, 1'b0, "miss_ch4");
    bus_write(22'o17777567, 16'h5555, 1'b1);
    probe(48'h0000_0000_0100, 48'h0000_0000_0100, "hibyte_ignored");
    bus_write(XBUF0, 16'h0055, 1'b0);
    probe(48'h0000_00FF_0100, 48'h0000_0055_0000, "xbuf0_word");

    // Simultaneous read and write: write wins, no pop
    rx_push(1, 8'h66);
    rd_q.push_back('{"rdwr_rbuf1", 16'h0066, 1'b1});
    bus_addr = RBUF1;
    bus_wdata = 16'h00FF;
    bus_rd = 1'b1;
    bus_wr = 1'b1;
    tick();
    bus_rd = 1'b0;
    bus_wr = 1'b0;
    bus_read(RBUF1, 16'h0066, 1'b1, "rbuf1_not_popped");

    // bus_init clears everything
    bus_write(RCSR0, 16'o000100, 1'b0);
    rx_wr = 4'b0011;
    rx_wdata[7:0] = 8'h77;
    rx_wdata[15:8] = 8'h12;
    tick();
    rx_wr = '0;
    tick();
    probe(48'h0000_0000_0010, 48'h0000_0000_0010, "rie0_irq");
    bus_init = 1'b1;
    tick();
    bus_init = 1'b0;
    tick();
    probe(48'hFFFF_FFFF_FFFF, 48'h0000_0000_0F00, "init_status");
    bus_read(RCSR0, 16'o000000, 1'b1, "init_rcsr0");
    bus_read(RCSR1, 16'o000000, 1'b1, "init_rcsr1");

    // MAINT bit and loopback
    bus_write(XCSR0, 16'o000104, 1'b0);
`ifdef DLART_LOOPBACK_EN
    bus_read(XCSR0, 16'o000204 | 16'o000100, 1'b1, "xcsr0_maint");
    bus_write(XBUF0, 16'h0033, 1'b0);
    probe(48'h0000_0000_0100, 48'h0000_0000_0100, "lb_tx_empty0");
    bus_read(RBUF0, 16'h0033, 1'b1, "lb_rbuf0");
`else
    bus_read(XCSR0, 16'o000300, 1'b1, "xcsr0_no_maint");
    bus_write(XBUF0, 16'h0033, 1'b0);
    probe(48'h0000_00FF_0100, 48'h0000_0033_0000, "no_lb_tx0");
    bus_read(RCSR0, 16'o000000, 1'b1, "no_lb_rcsr0");
`endif

    tick();
    if (rd_q.size() != 0 || st_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: rd=%0d st=%0d entries, expected 0", rd_q.size(), st_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
